// File: rtl/id_ex_if.sv
// ID/EX stage bus: decoder/register-file side (id_*), pipeline control
// (flush, hold, stall) and the registered EX side (ex_*).
// Optional macro ID_EX_STALL_CNT_EN adds the CNT_W parameter and stall_cnt.
`timescale 1ns/1ps
interface id_ex_if #(
  parameter int DATA_W     = 32,
  parameter int REG_ADDR_W = 5
`ifdef ID_EX_STALL_CNT_EN
  , parameter int CNT_W    = 16
`endif
);
  logic                  id_valid;
  logic                  id_reg_dest, id_branch, id_mem_read, id_mem_to_reg;
  logic                  id_mem_write, id_alu_src, id_reg_write;
  logic [1:0]            id_alu_op;
  logic [DATA_W-1:0]     id_rd1, id_rd2, id_imm, id_pc4;
  logic [REG_ADDR_W-1:0] id_rs, id_rt, id_rd;
  logic                  flush, hold, stall;
  logic                  ex_valid;
  logic                  ex_reg_dest, ex_branch, ex_mem_read, ex_mem_to_reg;
  logic                  ex_mem_write, ex_alu_src, ex_reg_write;
  logic [1:0]            ex_alu_op;
  logic [DATA_W-1:0]     ex_rd1, ex_rd2, ex_imm, ex_pc4;
  logic [REG_ADDR_W-1:0] ex_rs, ex_rt, ex_rd;
`ifdef ID_EX_STALL_CNT_EN
  logic [CNT_W-1:0]      stall_cnt;
`endif

  modport master (
    output id_valid, id_reg_dest, id_branch, id_mem_read, id_mem_to_reg,
           id_mem_write, id_alu_src, id_reg_write, id_alu_op,
           id_rd1, id_rd2, id_imm, id_pc4, id_rs, id_rt, id_rd, flush, hold,
    input  stall, ex_valid, ex_reg_dest, ex_branch, ex_mem_read, ex_mem_to_reg,
           ex_mem_write, ex_alu_src, ex_reg_write, ex_alu_op,
           ex_rd1, ex_rd2, ex_imm, ex_pc4, ex_rs, ex_rt, ex_rd
`ifdef ID_EX_STALL_CNT_EN
    , input stall_cnt
`endif
  );

  modport slave (
    input  id_valid, id_reg_dest, id_branch, id_mem_read, id_mem_to_reg,
           id_mem_write, id_alu_src, id_reg_write, id_alu_op,
           id_rd1, id_rd2, id_imm, id_pc4, id_rs, id_rt, id_rd, flush, hold,
    output stall, ex_valid, ex_reg_dest, ex_branch, ex_mem_read, ex_mem_to_reg,
           ex_mem_write, ex_alu_src, ex_reg_write, ex_alu_op,
           ex_rd1, ex_rd2, ex_imm, ex_pc4, ex_rs, ex_rt, ex_rd
`ifdef ID_EX_STALL_CNT_EN
    , output stall_cnt
`endif
  );
endinterface

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use hazard detection, branch flush and
// downstream hold. Optional macro ID_EX_STALL_CNT_EN adds a saturating
// count of hazard bubbles on stall_cnt.
`timescale 1ns/1ps
module id_ex_stage #(
  parameter int DATA_W     = 32,
  parameter int REG_ADDR_W = 5
`ifdef ID_EX_STALL_CNT_EN
  , parameter int CNT_W    = 16
`endif
) (
  input logic   clk,
  input logic   reset,
  id_ex_if.slave bus
);
  typedef struct packed {
    logic       regDest;
    logic       branch;
    logic       memRead;
    logic       memToReg;
    logic       memWrite;
    logic       aluSrc;
    logic       regWrite;
    logic [1:0] aluOp;
  } ctrl_t;

  typedef enum logic [1:0] {
    UPD_LOAD,
    UPD_FLUSH,
    UPD_HAZARD,
    UPD_HOLD
  } upd_t;

  ctrl_t                 idCtrl, exCtrl;
  logic                  exValid;
  logic [DATA_W-1:0]     exRd1, exRd2, exImm, exPc4;
  logic [REG_ADDR_W-1:0] exRs, exRt, exRd;
  logic                  hazard;
  upd_t                  updMode;

  assign idCtrl = '{regDest: bus.id_reg_dest, branch: bus.id_branch,
                    memRead: bus.id_mem_read, memToReg: bus.id_mem_to_reg,
                    memWrite: bus.id_mem_write, aluSrc: bus.id_alu_src,
                    regWrite: bus.id_reg_write, aluOp: bus.id_alu_op};

  // Load-use detection and update-priority selection (hold > flush > hazard)
  always_comb begin
    hazard  = exValid & exCtrl.memRead & bus.id_valid & (exRt != '0) &
              ((exRt == bus.id_rs) | (exRt == bus.id_rt));
    updMode = UPD_LOAD;
    if (bus.hold)       updMode = UPD_HOLD;
    else if (bus.flush) updMode = UPD_FLUSH;
    else if (hazard)    updMode = UPD_HAZARD;
  end

  // A flush must not stall, so the PC redirect can proceed
  assign bus.stall = bus.hold | (hazard & ~bus.flush);

  // Valid and control bits: bubbles and invalid slots carry no controls
  always_ff @(posedge clk) begin
    if (reset) begin
      exValid <= 1'b0;
      exCtrl  <= '0;
    end else begin
      case (updMode)
        UPD_FLUSH, UPD_HAZARD: begin
          exValid <= 1'b0;
          exCtrl  <= '0;
        end
        UPD_LOAD: begin
          exValid <= bus.id_valid;
          exCtrl  <= bus.id_valid ? idCtrl : '0;
        end
        default: ;
      endcase
    end
  end

  // Data fields and specifiers load on every non-hold edge, bubbles included
  always_ff @(posedge clk) begin
    if (reset) begin
      exRd1 <= '0;
      exRd2 <= '0;
      exImm <= '0;
      exPc4 <= '0;
      exRs  <= '0;
      exRt  <= '0;
      exRd  <= '0;
    end else if (updMode != UPD_HOLD) begin
      exRd1 <= bus.id_rd1;
      exRd2 <= bus.id_rd2;
      exImm <= bus.id_imm;
      exPc4 <= bus.id_pc4;
      exRs  <= bus.id_rs;
      exRt  <= bus.id_rt;
      exRd  <= bus.id_rd;
    end
  end

`ifdef ID_EX_STALL_CNT_EN
  logic [CNT_W-1:0] stallCnt;

  // Saturating count of hazard bubbles only (not hold or flush)
  always_ff @(posedge clk) begin
    if (reset) begin
      stallCnt <= '0;
    end else if (updMode == UPD_HAZARD && stallCnt != '1) begin
      stallCnt <= stallCnt + CNT_W'(1);
    end
  end

  assign bus.stall_cnt = stallCnt;
`endif

  assign bus.ex_valid      = exValid;
  assign bus.ex_reg_dest   = exCtrl.regDest;
  assign bus.ex_branch     = exCtrl.branch;
  assign bus.ex_mem_read   = exCtrl.memRead;
  assign bus.ex_mem_to_reg = exCtrl.memToReg;
  assign bus.ex_mem_write  = exCtrl.memWrite;
  assign bus.ex_alu_src    = exCtrl.aluSrc;
  assign bus.ex_reg_write  = exCtrl.regWrite;
  assign bus.ex_alu_op     = exCtrl.aluOp;
  assign bus.ex_rd1        = exRd1;
  assign bus.ex_rd2        = exRd2;
  assign bus.ex_imm        = exImm;
  assign bus.ex_pc4        = exPc4;
  assign bus.ex_rs         = exRs;
  assign bus.ex_rt         = exRt;
  assign bus.ex_rd         = exRd;
endmodule

// File: tb/tb_id_ex_stage.sv
// Self-checking bench for id_ex_stage: directed scenarios followed by random
// traffic, checked against a slot-level reference model.
`timescale 1ns/1ps
module tb_id_ex_stage;
  localparam int DATA_W     = 32;
  localparam int REG_ADDR_W = 5;
`ifdef ID_EX_STALL_CNT_EN
  localparam int CNT_W      = 2;
  localparam int CNT_MAX    = (1 << CNT_W) - 1;
`endif

  // ctrl bit order: regDest, branch, memRead, memToReg, memWrite, aluSrc,
  // regWrite, aluOp[1:0]  (memRead is bit 6)
  typedef struct packed {
    logic        valid;
    logic [8:0]  ctrl;
    logic [31:0] rd1, rd2, imm, pc4;
    logic [4:0]  rs, rt, rd;
  } slot_t;

  localparam logic [8:0] CTRL_ADDI = 9'b0_0000_1110;
  localparam logic [8:0] CTRL_LW   = 9'b0_0110_1100;

  logic  clk = 1'b0;
  logic  reset;
  slot_t id, model;
  logic  flushIn, holdIn, resetIn;
  int    cmpCnt = 0;
  int    errCnt = 0;
  int    cntModel = 0;

  always #5 clk = ~clk;

  id_ex_if #(.DATA_W(DATA_W), .REG_ADDR_W(REG_ADDR_W)
`ifdef ID_EX_STALL_CNT_EN
    , .CNT_W(CNT_W)
`endif
  ) bus ();

  id_ex_stage #(.DATA_W(DATA_W), .REG_ADDR_W(REG_ADDR_W)
`ifdef ID_EX_STALL_CNT_EN
    , .CNT_W(CNT_W)
`endif
  ) dut (.clk(clk), .reset(reset), .bus(bus));

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    cmpCnt++;
    assert (obs === exp) else begin
      errCnt++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic slot_t randInstr();
    slot_t s;
    s.valid = 1'b1;
    s.ctrl  = 9'($urandom);
    s.rd1   = $urandom;
    s.rd2   = $urandom;
    s.imm   = $urandom;
    s.pc4   = $urandom & 32'hFFFF_FFFC;
    s.rs    = 5'($urandom);
    s.rt    = 5'($urandom);
    s.rd    = 5'($urandom);
    return s;
  endfunction

  // A valid load in EX whose nonzero destination is a source of the ID instruction
  function automatic logic loadUse();
    return model.valid && model.ctrl[6] && id.valid && model.rt != 5'd0 &&
           (model.rt == id.rs || model.rt == id.rt);
  endfunction

  function automatic logic [8:0] obsCtrl();
    return {bus.ex_reg_dest, bus.ex_branch, bus.ex_mem_read, bus.ex_mem_to_reg,
            bus.ex_mem_write, bus.ex_alu_src, bus.ex_reg_write, bus.ex_alu_op};
  endfunction

  task automatic drive();
    reset        = resetIn;
    bus.flush    = flushIn;
    bus.hold     = holdIn;
    bus.id_valid = id.valid;
    {bus.id_reg_dest, bus.id_branch, bus.id_mem_read, bus.id_mem_to_reg,
     bus.id_mem_write, bus.id_alu_src, bus.id_reg_write, bus.id_alu_op} = id.ctrl;
    bus.id_rd1 = id.rd1;
    bus.id_rd2 = id.rd2;
    bus.id_imm = id.imm;
    bus.id_pc4 = id.pc4;
    bus.id_rs  = id.rs;
    bus.id_rt  = id.rt;
    bus.id_rd  = id.rd;
  endtask

  // Drive, check stall before the edge, advance the model, check EX after the edge
  task automatic cycle();
    logic hz;
    drive();
    #1;
    hz = loadUse();
    check("stall", 64'(bus.stall), 64'(holdIn | (hz & ~flushIn)));
    @(posedge clk);
    if (resetIn) begin
      model    = '0;
      cntModel = 0;
    end else if (!holdIn) begin
      if (flushIn || hz) begin
        model       = id;
        model.valid = 1'b0;
        model.ctrl  = '0;
        if (!flushIn && cntModel < (1 << 30)) cntModel++;
      end else begin
        model = id;
        if (!id.valid) model.ctrl = '0;
      end
    end
    #1;
    check("ex_valid", 64'(bus.ex_valid), 64'(model.valid));
    check("ex_ctrl", 64'(obsCtrl()), 64'(model.ctrl));
    check("ex_rd1", 64'(bus.ex_rd1), 64'(model.rd1));
    check("ex_rd2", 64'(bus.ex_rd2), 64'(model.rd2));
    check("ex_imm", 64'(bus.ex_imm), 64'(model.imm));
    check("ex_pc4", 64'(bus.ex_pc4), 64'(model.pc4));
    check("ex_regs", 64'({bus.ex_rs, bus.ex_rt, bus.ex_rd}),
          64'({model.rs, model.rt, model.rd}));
    check("ctrl_needs_valid", 64'((|obsCtrl()) & ~bus.ex_valid), 64'(0));
`ifdef ID_EX_STALL_CNT_EN
    check("stall_cnt", 64'(bus.stall_cnt),
          64'(cntModel > CNT_MAX ? CNT_MAX : cntModel));
`endif
  endtask

  initial begin
    // Reset for two cycles with nonzero inputs
    resetIn = 1'b1; flushIn = 1'b0; holdIn = 1'b0;
    id = randInstr();
    drive();
    @(posedge clk);
    #1;
    model = '0;
    id = randInstr();
    cycle();
    check("rst_valid", 64'(bus.ex_valid), 64'(0));
    check("rst_stall", 64'(bus.stall), 64'(0));
    resetIn = 1'b0;

    // ADDI-style pass-through
    id = randInstr();
    id.ctrl = CTRL_ADDI; id.rd1 = 32'h0000_0005; id.imm = 32'hFFFF_FFFC;
    cycle();
    check("addi_imm", 64'(bus.ex_imm), 64'(32'hFFFF_FFFC));
    check("addi_alu_op", 64'(bus.ex_alu_op), 64'(2'b10));
    check("addi_valid", 64'(bus.ex_valid), 64'(1));

    // Load-use on r8: exactly one bubble, then dependent instruction enters
    id = randInstr(); id.ctrl = CTRL_LW; id.rt = 5'd8;
    cycle();
    id = randInstr(); id.ctrl = CTRL_ADDI; id.rs = 5'd8;
    cycle();
    check("lu_bubble_valid", 64'(bus.ex_valid), 64'(0));
    check("lu_bubble_rw", 64'(bus.ex_reg_write), 64'(0));
    cycle();
    check("lu_dep_rs", 64'(bus.ex_rs), 64'(8));
    check("lu_dep_valid", 64'(bus.ex_valid), 64'(1));

    // Load to r0 never stalls
    id = randInstr(); id.ctrl = CTRL_LW; id.rt = 5'd0;
    cycle();
    id = randInstr(); id.ctrl = CTRL_ADDI; id.rs = 5'd0;
    drive(); #1;
    check("r0_no_stall", 64'(bus.stall), 64'(0));
    cycle();

    // Flush concurrent with load-use: no stall, bubble
    id = randInstr(); id.ctrl = CTRL_LW; id.rt = 5'd9;
    cycle();
    id = randInstr(); id.rs = 5'd9; flushIn = 1'b1;
    cycle();
    check("flush_valid", 64'(bus.ex_valid), 64'(0));
    flushIn = 1'b0;

    // Hold for three cycles with changing inputs, then release
    id = randInstr();
    cycle();
    holdIn = 1'b1;
    for (int i = 0; i < 3; i++) begin
      id = randInstr();
      cycle();
    end
    holdIn = 1'b0;
    id = randInstr();
    cycle();

    // Five hazard bubbles from a clean counter, with hold/flush interleaved
    resetIn = 1'b1;
    cycle();
    resetIn = 1'b0;
    for (int k = 0; k < 5; k++) begin
      id = randInstr(); id.ctrl = CTRL_LW; id.rt = 5'(k + 1);
      cycle();
      id = randInstr(); id.rt = 5'(k + 1);
      cycle();
`ifdef ID_EX_STALL_CNT_EN
      check("cnt_seq", 64'(bus.stall_cnt), 64'(k < 3 ? k + 1 : 3));
`endif
      holdIn = 1'b1;
      cycle();
      holdIn = 1'b0;
      flushIn = 1'b1;
      cycle();
      flushIn = 1'b0;
    end

    // Random traffic with narrow register range to provoke hazards
    for (int n = 0; n < 400; n++) begin
      id = randInstr();
      id.valid = ($urandom_range(0, 9) != 0);
      id.rs = 5'($urandom_range(0, 3));
      id.rt = 5'($urandom_range(0, 3));
      if ($urandom_range(0, 2) == 0) id.ctrl[6] = 1'b1;
      flushIn = ($urandom_range(0, 9) == 0);
      holdIn  = ($urandom_range(0, 7) == 0);
      resetIn = ($urandom_range(0, 39) == 0);
      cycle();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmpCnt, errCnt);
    $finish;
  end
endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
- ID/EX pipeline register, directly downstream of the opcode control decoder.
- Each cycle it latches the decoder's control bits together with register-file operands, immediate, register specifiers and PC+4.
- Contains the load-use hazard detector: it stalls PC and IF/ID and inserts a bubble into EX.
- Also supports branch flush and a downstream hold.

Parameters:
DATA_W, 32, width of operand, immediate and PC fields
REG_ADDR_W, 5, width of register specifiers
CNT_W, 16, width of stall counter (optional feature only)

Ports:
clk  input  1  rising-edge clock
reset  input  1  synchronous, active-high reset
id_valid  input  1  ID holds a real instruction
id_reg_dest, id_branch, id_mem_read, id_mem_to_reg, id_mem_write, id_alu_src, id_reg_write  input  1 each  control decoder outputs
id_alu_op  input  2  control decoder ALU op
id_rd1, id_rd2  input  DATA_W  register file read data
id_imm  input  DATA_W  sign-extended immediate
id_pc4  input  DATA_W  PC+4 of the ID instruction
id_rs, id_rt, id_rd  input  REG_ADDR_W  instruction register fields
flush  input  1  taken branch resolved downstream; squash the ID instruction
hold  input  1  downstream busy; freeze this stage
stall  output  1  freeze PC and IF/ID (combinational)
ex_valid  output  1  EX holds a real instruction
ex_reg_dest, ex_branch, ex_mem_read, ex_mem_to_reg, ex_mem_write, ex_alu_src, ex_reg_write  output  1 each  registered control bits
ex_alu_op  output  2  registered ALU op
ex_rd1, ex_rd2, ex_imm, ex_pc4  output  DATA_W  registered data fields
ex_rs, ex_rt, ex_rd  output  REG_ADDR_W  registered register specifiers
stall_cnt  output  CNT_W  bubble count (optional feature only)

Behaviour:
- All ex_* outputs register on the rising edge of clk. Latency is 1 cycle from ID to EX.
- Reset: every ex_* output is 0, including ex_valid, all control bits and all data fields. stall_cnt is 0.
- Hazard term: hz = ex_valid & ex_mem_read & id_valid & (ex_rt != 0) & ((ex_rt == id_rs) | (ex_rt == id_rt)).
- stall output = hold | (hz & ~flush). stall is purely combinational from current inputs and registers.
- Update priority each edge, highest first:
  1. reset: clear everything as above.
  2. hold: all ex_* registers keep their value; flush and hz are ignored this cycle. The flush source must keep flush asserted until hold drops.
  3. flush: bubble. ex_valid and all 9 control bits go to 0. Data fields and specifiers load the ID values.
  4. hz: bubble, identical to the flush case. Upstream is frozen by stall, so the same ID instruction is re-presented next cycle. By then ex_mem_read=0, so hz clears and the instruction enters EX after exactly 1 bubble.
  5. Normal: every field loads its id_* value. ex_valid loads id_valid. When id_valid=0, the control bits are also forced to 0.
- Any asserted ex control bit implies ex_valid=1. The EX/MEM/WB stages never see a write enable from an invalid slot.
- Simultaneous flush and hz: flush wins, stall=0, so the PC redirect proceeds.
- Reset asserted mid-stall or mid-hold: cleared on that edge. stall deasserts once reset clears ex_mem_read.
- Register 0 never causes a stall.

Optional Feature:
- Macro ID_EX_STALL_CNT_EN.
- Defined: the stall_cnt port exists. It increments by 1 on each edge where a hazard bubble is inserted (priority case 4 only; not counted during hold or flush). It saturates at all-ones and clears on reset.
- Undefined: the stall_cnt port and counter logic are absent. All other behaviour is identical.

Test Plan:
- Reset: hold reset 2 cycles with nonzero id_* inputs -> all ex_* = 0, stall=0.
- Pass-through: ADDI-style controls (alu_src=1, reg_write=1, alu_op=2'b10), id_rd1=0x0000_0005, id_imm=0xFFFF_FFFC -> identical values on ex_* exactly 1 cycle later, ex_valid=1.
- Load-use: LW with rt=8, next ID instruction has rs=8 -> stall=1 for exactly 1 cycle; EX gets 1 bubble (ex_valid=0, ex_reg_write=0); then the dependent instruction appears with rs=8. Repeat with ex_rt=0 -> no stall.
- Flush with concurrent hz: flush=1 while the load-use condition holds -> stall=0, next ex_valid=0 with all controls 0.
- Hold: hold=1 for 3 cycles while inputs change -> ex_* frozen, stall=1 throughout; on release the current ID values load.
- With ID_EX_STALL_CNT_EN and CNT_W=2: 5 load-use bubbles -> stall_cnt reads 1,2,3,3,3. Hold and flush cycles do not count.
